// File: rtl/apb_master_bridge.sv
`timescale 1ns/1ps
// apb_master_bridge
// Valid/ready command port to APB master bridge. Each accepted command runs
// one APB SETUP + ACCESS sequence. The read data and slave-error status are
// returned on a valid/ready response port. Only one transfer is outstanding
// at a time.
//
// Optional feature macro: APB_TIMEOUT_EN
//   When defined, an ACCESS phase that waits TIMEOUT_CYCLES cycles with
//   PREADY low is aborted and answered with rsp_err=1, rsp_rdata=0.
//   When undefined, the bridge waits for PREADY indefinitely.

module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,

   // command port
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,

   // response port
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,

   // APB master interface
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic                    PREADY,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PSLVERR
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t state;

`ifdef APB_TIMEOUT_EN
   // The counter only ever needs to reach TIMEOUT_CYCLES-1: the abort
   // decision is made on the edge that would take it to TIMEOUT_CYCLES.
   localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_WIDTH-1:0] wait_cnt;
   logic                 limit_hit;

   // High in the ACCESS cycle whose PREADY=0 would be the last allowed wait.
   assign limit_hit = (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`endif

   // Bridge sequencer: every APB and response output is a register here.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         PSTRB     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wait_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  // Reads never drive write data or strobes onto the bus.
                  cmd_ready <= 1'b0;
                  PSEL      <= 1'b1;
                  PENABLE   <= 1'b0;
                  PWRITE    <= cmd_write;
                  PADDR     <= cmd_addr;
                  PWDATA    <= cmd_write ? cmd_wdata : '0;
                  PSTRB     <= cmd_write ? cmd_strb  : '0;
                  state     <= SETUP;
               end
            end

            SETUP: begin
               PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state   <= ACCESS;
            end

            ACCESS: begin
               if (PREADY) begin
                  // PSLVERR and PRDATA are only meaningful on this edge.
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_err   <= PSLVERR;
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
`ifdef APB_TIMEOUT_EN
               else if (limit_hit) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end

            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
`timescale 1ns/1ps
// tb_apb_master_bridge
// Directed testbench for apb_master_bridge with a small APB slave memory
// model. If APB_TIMEOUT_EN is defined, the timeout scenario also runs. The
// DUT is built with TIMEOUT_CYCLES=4.

module tb_apb_master_bridge;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic [3:0]  PSTRB;

   int          total = 0;
   int          bad = 0;
   int          slave_wait = 0;
   logic        slave_err = 1'b0;
   int          wait_ctr;
   logic [31:0] mem [0:63] = '{default: 32'h0};

   apb_master_bridge #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .PCLK(PCLK),
      .PRESETn(PRESETn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .PSEL(PSEL),
      .PENABLE(PENABLE),
      .PWRITE(PWRITE),
      .PADDR(PADDR),
      .PWDATA(PWDATA),
      .PSTRB(PSTRB),
      .PREADY(PREADY),
      .PRDATA(PRDATA),
      .PSLVERR(PSLVERR)
   );

   // 100 MHz clock
   always #5 PCLK = ~PCLK;

   // Slave model: PREADY after slave_wait wait cycles. PSLVERR stays high while
   // waiting so that a bridge sampling it too early is caught. PRDATA carries
   // junk on writes so that a bridge that does not zero write responses is caught.
   assign PREADY  = PSEL && PENABLE && (wait_ctr >= slave_wait);
   assign PSLVERR = PREADY ? slave_err : 1'b1;
   assign PRDATA  = (PSEL && PENABLE && !PWRITE) ? mem[PADDR[5:0]] : 32'h5A5A_5A5A;

   // Slave model: wait-state counter and byte-strobed memory write
   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wait_ctr <= 0;
      end else begin
         if (PSEL && PENABLE && !PREADY) wait_ctr <= wait_ctr + 1;
         else wait_ctr <= 0;
         if (PSEL && PENABLE && PREADY && PWRITE) begin
            for (int b = 0; b < 4; b++)
               if (PSTRB[b]) mem[PADDR[5:0]][8*b +: 8] <= PWDATA[8*b +: 8];
         end
      end
   end

   // Waits (bounded) for cmd_ready, then presents one command for one accept edge
   task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
      int n = 0;
      @(negedge PCLK);
      while (!cmd_ready && n < 20) begin
         @(negedge PCLK);
         n++;
      end
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL issue_cmd_ready: got=%0b want=1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_strb  = s;
      @(posedge PCLK);
      #1 cmd_valid = 1'b0;
   endtask

   // Accepts the response on the next edge
   task automatic consume();
      rsp_ready = 1'b1;
      @(posedge PCLK);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready} !== 6'b0) begin
         bad++;
         $display("[TB] FAIL reset_ctrl: got=%b want=000000",
                  {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready});
      end
      total++;
      if ({PADDR, PWDATA, PSTRB, rsp_rdata} !== 100'h0) begin
         bad++;
         $display("[TB] FAIL reset_data: got=%h want=0", {PADDR, PWDATA, PSTRB, rsp_rdata});
      end
      PRESETn = 1'b1;
      #1;
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_release_ready_early: got=%0b want=0", cmd_ready);
      end
      @(negedge PCLK);
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_release_ready: got=%0b want=1", cmd_ready);
      end
   endtask

   task automatic test_write();
      slave_wait = 0;
      slave_err  = 1'b0;
      issue_cmd(1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF);
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid} !== 5'b10100) begin
         bad++;
         $display("[TB] FAIL wr_setup_ctrl: got=%b want=10100",
                  {PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid});
      end
      total++;
      if ({PADDR, PWDATA, PSTRB} !== {32'd5, 32'hDEAD_BEEF, 4'hF}) begin
         bad++;
         $display("[TB] FAIL wr_setup_bus: got=%h want=%h", {PADDR, PWDATA, PSTRB},
                  {32'd5, 32'hDEAD_BEEF, 4'hF});
      end
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid} !== 4'b1110) begin
         bad++;
         $display("[TB] FAIL wr_access_ctrl: got=%b want=1110", {PSEL, PENABLE, PWRITE, rsp_valid});
      end
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE, rsp_valid, rsp_err, cmd_ready} !== 5'b00100) begin
         bad++;
         $display("[TB] FAIL wr_resp_ctrl: got=%b want=00100",
                  {PSEL, PENABLE, rsp_valid, rsp_err, cmd_ready});
      end
      total++;
      if ({rsp_rdata, PADDR} !== {32'h0, 32'd5}) begin
         bad++;
         $display("[TB] FAIL wr_resp_data: got=%h want=%h", {rsp_rdata, PADDR}, {32'h0, 32'd5});
      end
      consume();
      @(negedge PCLK);
      total++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL wr_consumed: got=%b want=01", {rsp_valid, cmd_ready});
      end
   endtask

   task automatic test_read();
      issue_cmd(1'b0, 32'd5, 32'h1234_5678, 4'hF);
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB} !== {3'b100, 32'd5, 32'h0, 4'h0}) begin
         bad++;
         $display("[TB] FAIL rd_setup: got=%h want=%h", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB},
                  {3'b100, 32'd5, 32'h0, 4'h0});
      end
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE} !== 2'b11) begin
         bad++;
         $display("[TB] FAIL rd_access: got=%b want=11", {PSEL, PENABLE});
      end
      @(negedge PCLK);
      total++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
         bad++;
         $display("[TB] FAIL rd_resp: got=%h want=%h", {rsp_valid, rsp_err, rsp_rdata},
                  {2'b10, 32'hDEAD_BEEF});
      end
      consume();
      @(negedge PCLK);
   endtask

   task automatic test_slverr();
      slave_err = 1'b1;
      issue_cmd(1'b0, 32'd40, 32'h0, 4'h0);
      repeat (3) @(negedge PCLK);
      total++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
         bad++;
         $display("[TB] FAIL err_resp: got=%h want=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 32'h0});
      end
      slave_err = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'd7;
      cmd_wdata = 32'h0000_1111;
      cmd_strb  = 4'h3;
      for (int i = 0; i < 2; i++) begin
         @(negedge PCLK);
         total++;
         if ({cmd_ready, PSEL, rsp_valid, rsp_err} !== 4'b0011) begin
            bad++;
            $display("[TB] FAIL err_blocked_%0d: got=%b want=0011", i,
                     {cmd_ready, PSEL, rsp_valid, rsp_err});
         end
      end
      consume();
      @(negedge PCLK);
      total++;
      if ({cmd_ready, PSEL, rsp_valid} !== 3'b100) begin
         bad++;
         $display("[TB] FAIL err_after_handshake: got=%b want=100", {cmd_ready, PSEL, rsp_valid});
      end
      @(posedge PCLK);
      #1 cmd_valid = 1'b0;
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b101, 32'd7}) begin
         bad++;
         $display("[TB] FAIL err_next_setup: got=%h want=%h", {PSEL, PENABLE, PWRITE, PADDR},
                  {3'b101, 32'd7});
      end
      repeat (2) @(negedge PCLK);
      total++;
      if ({rsp_valid, rsp_err} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL err_next_resp: got=%b want=10", {rsp_valid, rsp_err});
      end
      consume();
      @(negedge PCLK);
   endtask

   task automatic test_wait_states();
      slave_wait = 3;
      issue_cmd(1'b1, 32'd9, 32'hA5A5_0F0F, 4'h5);
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL ws_setup: got=%b want=10", {PSEL, PENABLE});
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge PCLK);
         total++;
         if ({PSEL, PENABLE, PWRITE, rsp_valid, PADDR, PWDATA, PSTRB} !==
             {4'b1110, 32'd9, 32'hA5A5_0F0F, 4'h5}) begin
            bad++;
            $display("[TB] FAIL ws_access_%0d: got=%h want=%h", i,
                     {PSEL, PENABLE, PWRITE, rsp_valid, PADDR, PWDATA, PSTRB},
                     {4'b1110, 32'd9, 32'hA5A5_0F0F, 4'h5});
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge PCLK);
         total++;
         if ({rsp_valid, rsp_err, cmd_ready, PSEL, rsp_rdata} !== {4'b1000, 32'h0}) begin
            bad++;
            $display("[TB] FAIL ws_resp_hold_%0d: got=%h want=%h", i,
                     {rsp_valid, rsp_err, cmd_ready, PSEL, rsp_rdata}, {4'b1000, 32'h0});
         end
      end
      consume();
      @(negedge PCLK);
      slave_wait = 0;
      issue_cmd(1'b0, 32'd9, 32'h0, 4'hF);
      repeat (3) @(negedge PCLK);
      total++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h00A5_000F}) begin
         bad++;
         $display("[TB] FAIL ws_strobe_readback: got=%h want=%h", {rsp_valid, rsp_err, rsp_rdata},
                  {2'b10, 32'h00A5_000F});
      end
      consume();
      @(negedge PCLK);
   endtask

   task automatic test_back_to_back();
      logic [8:0] setup_mask = '0;
      logic [8:0] rsp_mask   = '0;
      slave_wait = 0;
      @(negedge PCLK);
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'd5;
      cmd_wdata = 32'h0;
      cmd_strb  = 4'h0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge PCLK);
         if (PSEL && !PENABLE) setup_mask[i] = 1'b1;
         if (rsp_valid) rsp_mask[i] = 1'b1;
         if (i == 5) cmd_valid = 1'b0;
      end
      rsp_ready = 1'b0;
      total++;
      if (setup_mask !== 9'b0_0010_0010) begin
         bad++;
         $display("[TB] FAIL b2b_setup_cycles: got=%b want=000100010", setup_mask);
      end
      total++;
      if (rsp_mask !== 9'b0_1000_1000) begin
         bad++;
         $display("[TB] FAIL b2b_rsp_cycles: got=%b want=010001000", rsp_mask);
      end
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout();
      slave_wait = 100;
      issue_cmd(1'b0, 32'd5, 32'h0, 4'h0);
      @(negedge PCLK);
      for (int i = 0; i < 4; i++) begin
         @(negedge PCLK);
         total++;
         if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL tmo_wait_%0d: got=%b want=110", i, {PSEL, PENABLE, rsp_valid});
         end
      end
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata} !== {4'b0011, 32'h0}) begin
         bad++;
         $display("[TB] FAIL tmo_abort: got=%h want=%h", {PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata},
                  {4'b0011, 32'h0});
      end
      consume();
      @(negedge PCLK);
      slave_wait = 0;
   endtask
`endif

   task automatic test_reset_mid();
      slave_wait = 100;
      issue_cmd(1'b0, 32'd5, 32'h0, 4'h0);
      repeat (2) @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE} !== 2'b11) begin
         bad++;
         $display("[TB] FAIL mid_in_access: got=%b want=11", {PSEL, PENABLE});
      end
      #2 PRESETn = 1'b0;
      #1;
      total++;
      if ({PSEL, PENABLE, rsp_valid, cmd_ready, PADDR} !== {4'b0000, 32'h0}) begin
         bad++;
         $display("[TB] FAIL mid_async_clear: got=%h want=0", {PSEL, PENABLE, rsp_valid, cmd_ready, PADDR});
      end
      @(negedge PCLK);
      PRESETn    = 1'b1;
      slave_wait = 0;
      #1;
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mid_release_ready_early: got=%0b want=0", cmd_ready);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge PCLK);
         total++;
         if ({PSEL, rsp_valid, cmd_ready} !== 3'b001) begin
            bad++;
            $display("[TB] FAIL mid_after_release_%0d: got=%b want=001", i, {PSEL, rsp_valid, cmd_ready});
         end
      end
   endtask

   // Runs all scenarios in sequence
   initial begin
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0;
      cmd_wdata = 32'h0;
      cmd_strb  = 4'h0;
      rsp_ready = 1'b0;
      $display("[TB] start");
      test_reset();
      test_write();
      test_read();
      test_slverr();
      test_wait_states();
      test_back_to_back();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
